wb_cmd_buffer: RTL and testbench
================================

Name: wb_cmd_buffer

Overview:
- Wishbone slave that gives the management SoC a memory-mapped path into the motor core.
- Buffers 32-bit move-command words in a FIFO and presents them through a valid/ready handshake.
- Exposes status, control and a consumed-command counter.
- Sits between the Caravel Wishbone port and the motor core's command input.

Parameters:
- DEPTH, 8, FIFO depth in words; must be a power of two, 2..256.
- BASE_ADDR, 32'h3000_0000, base of the 32-byte register window; bits [4:0] must be zero.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- cmd_data_o  out  32  FIFO head word.
- cmd_valid_o  out  1  head word valid.
- cmd_ready_i  in  1  core accepts the head word.
- move_done_i  in  1  core move-complete flag, same clock domain.
- buffer_dtr_o  out  1  buffer ready: room for at least DEPTH/2 more words.

Behaviour:
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0, cmd_valid_o=0, buffer_dtr_o=1.
  - FIFO empty, pointers 0; CTRL=0; overflow=0; COUNT=0.
- Address hit: cyc & stb & (adr[31:5]==BASE_ADDR[31:5]). A miss is never acked and has no side effects.
- Bus FSM, two states:
  - IDLE: on a hit, perform the access and go to ACK.
  - ACK: wbs_ack_o=1 for exactly one cycle, then IDLE.
  - Ack latency is 1 cycle; at most one access per 2 cycles.
  - Side effects happen on the IDLE->ACK edge only. A master holding stb through ACK does not repeat the access.
- wbs_dat_o is registered with ack and is 0 whenever ack=0.
- Register map, offsets adr[4:2]:
  - 0x00 CMD, W:
    - Write with sel=4'hF pushes wbs_dat_i.
    - Write with any other sel is acked and dropped, with no flag.
    - Read returns 0.
  - 0x04 STATUS, RO:
    - [0] empty, [1] full, [2] overflow (sticky), [3] move_done_i, [15:8] level, others 0.
  - 0x08 CTRL, RW:
    - [0] enable.
    - [1] flush: write-1 pulse, reads 0.
    - [2] clr_ovf: write-1 pulse, reads 0.
    - Reads return {31'b0, enable}.
  - 0x0C COUNT, RO: total words popped, 32-bit, wraps 2^32-1 -> 0.
  - 0x10..0x1C: reads 0, writes ignored, acked.
- FIFO:
  - cmd_valid_o = enable & ~empty.
  - cmd_data_o = mem[rptr], valid the same cycle as cmd_valid_o.
  - Pop when cmd_valid_o & cmd_ready_i; COUNT increments on each pop.
- Push when full:
  - Without a simultaneous pop: word dropped, overflow set, access still acked.
  - With a simultaneous pop: push accepted, level unchanged, no overflow.
- Clearing enable stops pops immediately; FIFO contents are retained.
- Flush: level -> 0 next cycle. Flush wins over a same-cycle pop, and that pop does not count. Overflow and COUNT are unaffected.
- clr_ovf clears overflow. A same-cycle overflowing push wins, so overflow stays 1.
- buffer_dtr_o = (level <= DEPTH/2), registered from the next-state level.
- Level width is $clog2(DEPTH)+1 so full is distinguishable from empty. Pointers wrap modulo DEPTH.
- Reset asserted mid-transfer: ack drops asynchronously; pending push or pop is lost; all state returns to reset values.

Decomposition:
- Package rapcore_wb_pkg holds:
  - register offset constants: CMD=3'd0, STATUS=3'd1, CTRL=3'd2, COUNT=3'd3;
  - STATUS and CTRL bit-index constants.
- Sub-module sync_fifo (DATA_W, DEPTH) provides push, pop, flush, full, empty, level, head.
  - Same reset style; no Wishbone knowledge.
- The Wishbone FSM, register decode and COUNT live in wb_cmd_buffer.

Test Plan:
- Reset, then read STATUS -> 0x0000_0001; buffer_dtr_o=1; cmd_valid_o=0; ack exactly 1 cycle after stb, high for 1 cycle.
- Push 0x11, 0x22, 0x33; CTRL=1; cmd_ready_i=1 -> cmd_data_o is 0x11, 0x22, 0x33 on consecutive cycles; COUNT=3; STATUS=0x0000_0009 with move_done_i=1.
- enable=0; push 9 words 0..8 -> STATUS full=1, overflow=1, level=8; then enable -> drains 0..7 only. Write CTRL=0x4 -> overflow=0.
- FIFO full; push 0xAA on the same cycle as a pop -> accepted, no overflow, 0xAA is the last word out. buffer_dtr_o falls when level reaches 5 and rises when it returns to 4.
- Level 5; write CTRL=0x3 with cmd_ready_i=1 -> level 0 next cycle; COUNT excludes the flush-cycle pop.
- Access at BASE_ADDR+0x40 -> no ack, no state change. Sel=4'h3 write to CMD -> acked, level unchanged. Assert wb_rst_i mid-ACK -> ack=0 immediately.

Source files
------------

// File: rtl/rapcore_wb_pkg.sv
// Shared register offsets, bit positions and bus FSM states for the Wishbone
// command buffer.
package rapcore_wb_pkg;

    localparam logic [2:0] REG_CMD    = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_COUNT  = 3'd3;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_DONE    = 3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_CLR_OVF = 2;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush, combinational head word and a registered
// "at least half empty" flag derived from the next-state level.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [DATA_W-1:0]          head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       half_room
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr_reg, wptr_next;
    logic [AW-1:0]     rptr_reg, rptr_next;
    logic [LW-1:0]     level_reg, level_next;
    logic              half_room_reg;
    logic              pop_ok, push_ok;

    assign empty     = (level_reg == '0);
    assign full      = (level_reg == LW'(DEPTH));
    assign level     = level_reg;
    assign head      = mem[rptr_reg];
    assign half_room = half_room_reg;

    // A push into a full FIFO only fits when the head leaves in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wptr_next  = wptr_reg;
        rptr_next  = rptr_reg;
        level_next = level_reg;
        if (flush) begin
            wptr_next  = '0;
            rptr_next  = '0;
            level_next = '0;
        end else begin
            wptr_next  = wptr_reg + AW'(push_ok);
            rptr_next  = rptr_reg + AW'(pop_ok);
            level_next = level_reg + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            level_reg     <= '0;
            half_room_reg <= 1'b1;
        end else begin
            wptr_reg      <= wptr_next;
            rptr_reg      <= rptr_next;
            level_reg     <= level_next;
            half_room_reg <= (level_next <= LW'(DEPTH / 2));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/wb_cmd_buffer.sv
// Wishbone slave that queues motor move commands for the core and exposes
// status, control and a consumed-command counter.
module wb_cmd_buffer
    import rapcore_wb_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] cmd_data_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    input  logic        move_done_i,
    output logic        buffer_dtr_o
);

    localparam int LW = $clog2(DEPTH) + 1;

    bus_state_t    state_reg, state_next;
    logic [31:0]   rdata_reg;
    logic          enable_reg;
    logic          ovf_reg;
    logic [31:0]   count_reg;

    logic          hit, access;
    logic [2:0]    reg_sel;
    logic          push, wr_ctrl, flush, clr_ovf;
    logic          pop_fire, pop_counted, ovf_event;
    logic [31:0]   rdata;
    logic          fifo_empty, fifo_full;
    logic [LW-1:0] fifo_level;
    logic          unused_adr_bits;

    assign unused_adr_bits = &{1'b0, wbs_adr_i[1:0]};

    assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign access  = (state_reg == BUS_IDLE) & hit;
    assign reg_sel = wbs_adr_i[4:2];

    assign push    = access & wbs_we_i & (reg_sel == REG_CMD) & (wbs_sel_i == 4'hF);
    assign wr_ctrl = access & wbs_we_i & (reg_sel == REG_CTRL);
    assign flush   = wr_ctrl & wbs_dat_i[CTRL_FLUSH];
    assign clr_ovf = wr_ctrl & wbs_dat_i[CTRL_CLR_OVF];

    assign cmd_valid_o = enable_reg & ~fifo_empty;
    assign pop_fire    = cmd_valid_o & cmd_ready_i;
    // A flush discards the head, so a coincident handshake is not a consumed command.
    assign pop_counted = pop_fire & ~flush;
    assign ovf_event   = push & fifo_full & ~pop_fire;

    assign wbs_ack_o = (state_reg == BUS_ACK);
    assign wbs_dat_o = rdata_reg;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            BUS_IDLE: if (hit) state_next = BUS_ACK;
            BUS_ACK:  state_next = BUS_IDLE;
            default:  state_next = BUS_IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_STATUS: begin
                rdata[ST_EMPTY] = fifo_empty;
                rdata[ST_FULL]  = fifo_full;
                rdata[ST_OVF]   = ovf_reg;
                rdata[ST_DONE]  = move_done_i;
                rdata[15:8]     = 8'(fifo_level);
            end
            REG_CTRL:  rdata[CTRL_EN] = enable_reg;
            REG_COUNT: rdata = count_reg;
            default:   rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg  <= BUS_IDLE;
            rdata_reg  <= '0;
            enable_reg <= 1'b0;
            ovf_reg    <= 1'b0;
            count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            rdata_reg <= (access && !wbs_we_i) ? rdata : 32'h0;
            if (wr_ctrl) begin
                enable_reg <= wbs_dat_i[CTRL_EN];
            end
            ovf_reg   <= (ovf_reg & ~clr_ovf) | ovf_event;
            count_reg <= count_reg + 32'(pop_counted);
        end
    end

    sync_fifo #(
        .DATA_W (32),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (push),
        .push_data (wbs_dat_i),
        .pop       (pop_fire),
        .flush     (flush),
        .head      (cmd_data_o),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level),
        .half_room (buffer_dtr_o)
    );

endmodule

// File: tb/tb_wb_cmd_buffer.sv
// Directed bench for wb_cmd_buffer: bus timing, FIFO ordering, overflow,
// flush, level watermark, address decode and asynchronous reset.
module tb_wb_cmd_buffer;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] OFF_CMD    = 32'h00;
    localparam logic [31:0] OFF_STATUS = 32'h04;
    localparam logic [31:0] OFF_CTRL   = 32'h08;
    localparam logic [31:0] OFF_COUNT  = 32'h0C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat_i = '0, adr = '0;
    logic        ack;
    logic [31:0] dat_o;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        move_done = 1'b0;
    logic        dtr;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    wb_cmd_buffer #(.DEPTH(8), .BASE_ADDR(BASE)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs_stb_i    (stb),
        .wbs_cyc_i    (cyc),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_dat_i    (dat_i),
        .wbs_adr_i    (adr),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (dat_o),
        .cmd_data_o   (cmd_data),
        .cmd_valid_o  (cmd_valid),
        .cmd_ready_i  (cmd_ready),
        .move_done_i  (move_done),
        .buffer_dtr_o (dtr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Starts at least 1 ns after a rising edge; returns 1 ns after the ack edge.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic expect_ack,
                           output logic [31:0] rdata);
        int lat;
        logic seen;
        lat = 0;
        rdata = '0;
        if (ack) begin
            @(posedge clk); #1;
        end
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        while (!ack && lat < 4) begin
            @(posedge clk); #1;
            lat++;
        end
        seen = ack;
        if (seen) rdata = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (expect_ack) check("ack_latency", 32'(lat), 32'd1);
        else            check("miss_no_ack", 32'(seen), 32'd0);
        $display("wb %s adr=%08h dat=%08h sel=%h ack=%0d rdata=%08h",
                 w ? "WR" : "RD", a, d, s, seen, rdata);
    endtask

    task automatic wb_wr(input logic [31:0] off, input logic [31:0] d);
        logic [31:0] unused;
        wb_xfer(1'b1, BASE + off, d, 4'hF, 1'b1, unused);
    endtask

    task automatic wb_rd(input logic [31:0] off, output logic [31:0] d);
        wb_xfer(1'b0, BASE + off, 32'h0, 4'hF, 1'b1, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #15;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", dat_o, 32'h0);
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_dtr", 32'(dtr), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        wb_rd(OFF_STATUS, rd);
        check("status_reset", rd, 32'h0000_0001);
        @(posedge clk); #1;
        check("ack_one_cycle", 32'(ack), 32'd0);

        // Three words drain in order on consecutive cycles
        wb_wr(OFF_CMD, 32'h11);
        wb_wr(OFF_CMD, 32'h22);
        wb_wr(OFF_CMD, 32'h33);
        check("valid_disabled", 32'(cmd_valid), 32'd0);
        cmd_ready = 1'b1;
        wb_wr(OFF_CTRL, 32'h1);
        check("drain_d0", cmd_data, 32'h11);
        check("drain_v0", 32'(cmd_valid), 32'd1);
        @(posedge clk); #1;
        check("drain_d1", cmd_data, 32'h22);
        @(posedge clk); #1;
        check("drain_d2", cmd_data, 32'h33);
        @(posedge clk); #1;
        check("drain_empty", 32'(cmd_valid), 32'd0);
        cmd_ready = 1'b0;
        wb_rd(OFF_COUNT, rd);
        check("count_3", rd, 32'd3);
        move_done = 1'b1;
        wb_rd(OFF_STATUS, rd);
        check("status_done", rd, 32'h0000_0009);
        move_done = 1'b0;

        // Overflow: nine pushes into eight slots
        wb_wr(OFF_CTRL, 32'h0);
        for (int i = 0; i < 9; i++) wb_wr(OFF_CMD, 32'(i));
        wb_rd(OFF_STATUS, rd);
        check("status_ovf", rd, 32'h0000_0806);
        check("dtr_full", 32'(dtr), 32'd0);
        wb_rd(OFF_CTRL, rd);
        check("ctrl_rd0", rd, 32'h0);
        cmd_ready = 1'b1;
        wb_wr(OFF_CTRL, 32'h1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_drain_%0d", i), cmd_data, 32'(i));
            @(posedge clk); #1;
        end
        check("ovf_drain_end", 32'(cmd_valid), 32'd0);
        cmd_ready = 1'b0;
        wb_rd(OFF_CTRL, rd);
        check("ctrl_rd1", rd, 32'h1);
        wb_rd(OFF_COUNT, rd);
        check("count_11", rd, 32'd11);
        wb_wr(OFF_CTRL, 32'h4);
        wb_rd(OFF_STATUS, rd);
        check("status_clr_ovf", rd, 32'h0000_0001);

        // Watermark on fill, push into a full FIFO alongside a pop
        for (int i = 0; i < 8; i++) begin
            wb_wr(OFF_CMD, 32'h100 + 32'(i));
            check($sformatf("dtr_fill_%0d", i + 1), 32'(dtr), (i + 1 <= 4) ? 32'd1 : 32'd0);
        end
        wb_wr(OFF_CTRL, 32'h1);
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        wb_wr(OFF_CMD, 32'hAA);
        cmd_ready = 1'b0;
        wb_rd(OFF_STATUS, rd);
        check("status_push_pop", rd, 32'h0000_0802);
        cmd_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            check($sformatf("dtr_drain_%0d", i), 32'(dtr), (8 - i <= 4) ? 32'd1 : 32'd0);
            if (i < 8)
                check($sformatf("pp_data_%0d", i), cmd_data,
                      (i == 7) ? 32'hAA : 32'h101 + 32'(i));
            else
                check("pp_empty", 32'(cmd_valid), 32'd0);
            @(posedge clk); #1;
        end
        cmd_ready = 1'b0;

        // Flush with a coincident handshake
        for (int i = 0; i < 5; i++) wb_wr(OFF_CMD, 32'h200 + 32'(i));
        check("dtr_level5", 32'(dtr), 32'd0);
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        wb_wr(OFF_CTRL, 32'h3);
        check("flush_valid", 32'(cmd_valid), 32'd0);
        cmd_ready = 1'b0;
        check("flush_dtr", 32'(dtr), 32'd1);
        wb_rd(OFF_STATUS, rd);
        check("status_flush", rd, 32'h0000_0001);
        wb_rd(OFF_COUNT, rd);
        check("count_20", rd, 32'd20);

        // Decode: out-of-window miss, partial-select CMD, reserved and CMD reads
        wb_xfer(1'b1, BASE + 32'h40, 32'h55, 4'hF, 1'b0, rd);
        @(posedge clk); #1;
        wb_xfer(1'b1, BASE + OFF_CMD, 32'h66, 4'h3, 1'b1, rd);
        wb_rd(OFF_STATUS, rd);
        check("status_decode", rd, 32'h0000_0001);
        wb_rd(32'h14, rd);
        check("reserved_rd", rd, 32'h0);
        wb_rd(OFF_CMD, rd);
        check("cmd_rd", rd, 32'h0);

        // Reset asserted while ack is high
        wb_wr(OFF_CMD, 32'h77);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + OFF_CTRL; dat_i = 32'h1; sel = 4'hF;
        @(posedge clk); #1;
        check("ack_before_rst", 32'(ack), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("ack_async_rst", 32'(ack), 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        check("post_rst_dtr", 32'(dtr), 32'd1);
        check("post_rst_valid", 32'(cmd_valid), 32'd0);
        wb_rd(OFF_STATUS, rd);
        check("post_rst_status", rd, 32'h0000_0001);
        wb_rd(OFF_COUNT, rd);
        check("post_rst_count", rd, 32'h0);
        wb_rd(OFF_CTRL, rd);
        check("post_rst_ctrl", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
